// File: rtl/wb_pipe_reg.sv
// LSU -> write-back pipeline register with valid/ready handshake and optional 2-entry skid buffer.
// Define WB_PIPE_INSTRET_CNT_EN to add the 64-bit retired-entry counter output instret_cnt_o.
module wb_pipe_reg #(
  parameter int DW   = 32,
  parameter int RAW  = 5,
  parameter int CAW  = 12,
  parameter int SKID = 1
) (
  input  logic           clk_i,
  input  logic           n_rst_i,
  input  logic           flush_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           rd_we_i,
  input  logic [RAW-1:0] rd_wa_i,
  input  logic [DW-1:0]  rd_wd_i,
  input  logic           csr_we_i,
  input  logic [CAW-1:0] csr_waddr_i,
  input  logic [DW-1:0]  csr_wdata_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           rd_we_o,
  output logic [RAW-1:0] rd_addr_o,
  output logic [DW-1:0]  rd_wdata_o,
  output logic           csr_we_o,
  output logic [CAW-1:0] csr_waddr_o,
  output logic [DW-1:0]  csr_wdata_o,
`ifdef WB_PIPE_INSTRET_CNT_EN
  output logic [63:0]    instret_cnt_o,
`endif
  output logic           instret_incr_o
);

  typedef struct packed {
    logic           rd_we;
    logic [RAW-1:0] rd_wa;
    logic [DW-1:0]  rd_wd;
    logic           csr_we;
    logic [CAW-1:0] csr_waddr;
    logic [DW-1:0]  csr_wdata;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  logic   ready_q;
  logic   accept;
  logic   drain;

  assign in_entry = '{
    rd_we:     rd_we_i,
    rd_wa:     rd_wa_i,
    rd_wd:     rd_wd_i,
    csr_we:    csr_we_i,
    csr_waddr: csr_waddr_i,
    csr_wdata: csr_wdata_i
  };

  // With the skid buffer, ready comes straight from a flop so downstream
  // back-pressure never reaches upstream combinationally.
  assign out_valid_o = (state != EMPTY);
  assign in_ready_o  = (SKID != 0) ? ready_q : (~out_valid_o | out_ready_i);
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign drain       = out_valid_o & out_ready_i;

  assign rd_we_o     = head.rd_we;
  assign rd_addr_o   = head.rd_wa;
  assign rd_wdata_o  = head.rd_wd;
  assign csr_we_o    = head.csr_we;
  assign csr_waddr_o = head.csr_waddr;
  assign csr_wdata_o = head.csr_wdata;

  // NOTE: the head and skid data registers are reset too, because head drives the
  // outputs directly and write enables must read 0 whenever nothing is valid.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state          <= EMPTY;
      head           <= '0;
      skid           <= '0;
      ready_q        <= 1'b1;
      instret_incr_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch below reads the
      // pre-edge values of state/head/skid, so branch order does not matter.
      instret_incr_o <= drain & ~flush_i;
      if (flush_i) begin
        state   <= EMPTY;
        head    <= '0;
        skid    <= '0;
        ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state <= HALF;
              head  <= in_entry;
            end
          end
          HALF: begin
            if (accept && drain) begin
              head <= in_entry;
            end else if (accept && (SKID != 0)) begin
              state   <= FULL;
              skid    <= in_entry;
              ready_q <= 1'b0;
            end else if (drain) begin
              state <= EMPTY;
              head  <= '0;
            end
          end
          FULL: begin
            if (drain) begin
              state   <= HALF;
              head    <= skid;
              skid    <= '0;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef WB_PIPE_INSTRET_CNT_EN
  // Survives flush; only reset clears it. Wraps naturally at 2^64.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      instret_cnt_o <= '0;
    end else if (instret_incr_o) begin
      instret_cnt_o <= instret_cnt_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: one SKID=1 and one SKID=0 instance share stimulus,
// each tracked by its own FIFO scoreboard; table rows also carry hand-derived SKID=1 flags.
module tb_wb_pipe_reg;

  localparam int EW = 1 + 5 + 32 + 1 + 12 + 32;

  typedef struct {
    logic        v;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        fl;
    logic        ev;   // expected out_valid (SKID=1)
    logic        er;   // expected in_ready  (SKID=1)
    logic        ei;   // expected instret_incr (SKID=1)
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  logic flush, in_valid, out_ready;
  logic rd_we, csr_we;
  logic [4:0]  rd_wa;
  logic [31:0] rd_wd, csr_wdata;
  logic [11:0] csr_waddr;

  logic in_ready1, out_valid1, rd_we1, csr_we1, incr1;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_wdata1, csr_wdata1;
  logic [11:0] csr_waddr1;
  logic in_ready0, out_valid0, rd_we0, csr_we0, incr0;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_wdata0, csr_wdata0;
  logic [11:0] csr_waddr0;
`ifdef WB_PIPE_INSTRET_CNT_EN
  logic [63:0] cnt1, cnt0;
`endif

  logic [EW-1:0] head1, head0;
  assign head1 = {rd_we1, rd_addr1, rd_wdata1, csr_we1, csr_waddr1, csr_wdata1};
  assign head0 = {rd_we0, rd_addr0, rd_wdata0, csr_we0, csr_waddr0, csr_wdata0};

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  logic [EW-1:0] q1[$];
  logic [EW-1:0] q0[$];
  logic exp_incr0 = 1'b0;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DW(32), .RAW(5), .CAW(12), .SKID(1)) dut1 (
    .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .rd_we_i(rd_we), .rd_wa_i(rd_wa), .rd_wd_i(rd_wd),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .rd_we_o(rd_we1), .rd_addr_o(rd_addr1), .rd_wdata_o(rd_wdata1),
    .csr_we_o(csr_we1), .csr_waddr_o(csr_waddr1), .csr_wdata_o(csr_wdata1),
`ifdef WB_PIPE_INSTRET_CNT_EN
    .instret_cnt_o(cnt1),
`endif
    .instret_incr_o(incr1)
  );

  wb_pipe_reg #(.DW(32), .RAW(5), .CAW(12), .SKID(0)) dut0 (
    .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .rd_we_i(rd_we), .rd_wa_i(rd_wa), .rd_wd_i(rd_wd),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .rd_we_o(rd_we0), .rd_addr_o(rd_addr0), .rd_wdata_o(rd_wdata0),
    .csr_we_o(csr_we0), .csr_waddr_o(csr_waddr0), .csr_wdata_o(csr_wdata0),
`ifdef WB_PIPE_INSTRET_CNT_EN
    .instret_cnt_o(cnt0),
`endif
    .instret_incr_o(incr0)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry payload derived from address/data so every field is exercised.
  function automatic logic [EW-1:0] mk(input logic [4:0] wa, input logic [31:0] wd);
    return {(wa != 5'd0), wa, wd, wa[0], {7'h06, wa}, wd ^ 32'hFFFF_0000};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                               input logic rdy, input logic fl,
                               input logic ev, input logic er, input logic ei);
    vec_t t;
    t.v = v; t.wa = wa; t.wd = wd; t.rdy = rdy; t.fl = fl;
    t.ev = ev; t.er = er; t.ei = ei;
    return t;
  endfunction

  task automatic add(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rdy, input logic fl,
                     input logic ev, input logic er, input logic ei);
    tbl.push_back(mkv(v, wa, wd, rdy, fl, ev, er, ei));
  endtask

  // One cycle: drive at negedge, compare settled outputs, advance both scoreboards.
  task automatic step(input vec_t t);
    logic [EW-1:0] e;
    logic v0m, r0m, acc, drn;
    e = mk(t.wa, t.wd);
    in_valid  = t.v;
    {rd_we, rd_wa, rd_wd, csr_we, csr_waddr, csr_wdata} = e;
    out_ready = t.rdy;
    flush     = t.fl;
    #1;
    check("valid1", out_valid1, t.ev);
    check("ready1", in_ready1, t.er);
    check("incr1", incr1, t.ei);
    check("head1", head1, (q1.size() > 0) ? q1[0] : '0);
    v0m = (q0.size() > 0);
    r0m = !v0m || t.rdy;
    check("valid0", out_valid0, v0m);
    check("ready0", in_ready0, r0m);
    check("incr0", incr0, exp_incr0);
    check("head0", head0, v0m ? q0[0] : '0);

    acc = t.v && (q1.size() < 2) && !t.fl;
    drn = (q1.size() > 0) && t.rdy;
    if (drn) void'(q1.pop_front());
    if (acc) q1.push_back(e);
    if (t.fl) q1.delete();

    acc = t.v && r0m && !t.fl;
    drn = v0m && t.rdy;
    exp_incr0 = drn && !t.fl;
    if (drn) void'(q0.pop_front());
    if (acc) q0.push_back(e);
    if (t.fl) q0.delete();
    @(negedge clk);
  endtask

  task automatic async_reset_test();
    step(mkv(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_valid1", out_valid1, 1'b0);
    check("rst_head1", head1, '0);
    check("rst_ready1", in_ready1, 1'b1);
    check("rst_incr1", incr1, 1'b0);
    check("rst_valid0", out_valid0, 1'b0);
    check("rst_head0", head0, '0);
    q1.delete();
    q0.delete();
    exp_incr0 = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("post_rst_ready1", in_ready1, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    {rd_we, rd_wa, rd_wd, csr_we, csr_waddr, csr_wdata} = '0;

    // v  wa     wd         rdy fl  ev er ei
    // Back-to-back stream with out_ready high
    add(1, 5'd1, 32'h11, 1, 0, 0, 1, 0);
    add(1, 5'd2, 32'h22, 1, 0, 1, 1, 0);
    add(1, 5'd3, 32'h33, 1, 0, 1, 1, 1);
    add(1, 5'd4, 32'h44, 1, 0, 1, 1, 1);
    add(0, 5'd0, 32'h0,  1, 0, 1, 1, 1);
    add(0, 5'd0, 32'h0,  1, 0, 0, 1, 1);
    add(0, 5'd0, 32'h0,  1, 0, 0, 1, 0);
    // Back-pressure: A, B fill both slots, C held upstream until ready returns
    add(1, 5'd10, 32'hA, 0, 0, 0, 1, 0);
    add(1, 5'd11, 32'hB, 0, 0, 1, 1, 0);
    add(1, 5'd12, 32'hC, 0, 0, 1, 0, 0);
    add(1, 5'd12, 32'hC, 1, 0, 1, 0, 0);
    add(1, 5'd12, 32'hC, 1, 0, 1, 1, 1);
    add(0, 5'd0,  32'h0, 1, 0, 1, 1, 1);
    add(0, 5'd0,  32'h0, 1, 0, 0, 1, 1);
    add(0, 5'd0,  32'h0, 1, 0, 0, 1, 0);
    // Flush while FULL and stalled
    add(1, 5'd13, 32'hD, 0, 0, 0, 1, 0);
    add(1, 5'd14, 32'hE, 0, 0, 1, 1, 0);
    add(0, 5'd0,  32'h0, 0, 1, 1, 0, 0);
    add(0, 5'd0,  32'h0, 0, 0, 0, 1, 0);
    // Flush on the same edge as an incoming entry
    add(1, 5'd15, 32'hF, 1, 1, 0, 1, 0);
    add(0, 5'd0,  32'h0, 1, 0, 0, 1, 0);
    // Drain coinciding with flush: delivered but no retire pulse
    add(1, 5'd16, 32'h6, 0, 0, 0, 1, 0);
    add(1, 5'd17, 32'h7, 1, 1, 1, 1, 0);
    add(0, 5'd0,  32'h0, 1, 0, 0, 1, 0);
    // After async reset: continuous input, out_ready 1,0,1 (SKID=0 ready tracking)
    add(1, 5'd21, 32'h101, 1, 0, 0, 1, 0);
    add(1, 5'd22, 32'h102, 0, 0, 1, 1, 0);
    add(1, 5'd22, 32'h102, 1, 0, 1, 0, 0);
    add(1, 5'd23, 32'h103, 1, 0, 1, 1, 1);
    add(0, 5'd0,  32'h0,   1, 0, 1, 1, 1);
    add(0, 5'd0,  32'h0,   1, 0, 0, 1, 1);
    add(0, 5'd0,  32'h0,   1, 0, 0, 1, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("init_valid1", out_valid1, 1'b0);
    check("init_ready1", in_ready1, 1'b1);
    check("init_head1", head1, '0);
    check("init_incr1", incr1, 1'b0);
`ifdef WB_PIPE_INSTRET_CNT_EN
    check("init_cnt1", cnt1, 64'd0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 24) async_reset_test();
      step(tbl[i]);
    end

`ifdef WB_PIPE_INSTRET_CNT_EN
    check("cnt1_after_seq", cnt1, 64'd3);
    check("cnt0_after_seq", cnt0, 64'd3);
`endif
    check("q1_empty", q1.size(), 0);
    check("q0_empty", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
